// File: rtl/tx_frame_scheduler_pkg.sv
// Shared definitions for the TX frame scheduler: FSM state encodings,
// source identifiers and small arithmetic helpers.
package tx_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XMIT  = 2'd2,
    ST_IFG   = 2'd3
  } state_t;

  typedef enum logic {
    SRC_TS = 1'b0,
    SRC_BE = 1'b1
  } src_t;

  localparam int unsigned BYTE_CNT_W = 11;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned OVF_CNT_W = 8;

  function automatic logic [OVF_CNT_W-1:0] sat_inc8(input logic [OVF_CNT_W-1:0] v);
    return (v == '1) ? v : v + OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_ifg_timer.sv
// Loadable down-counter used to time the inter-frame gap; done while zero.
module tx_frame_scheduler_ifg_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] iv_load_val,
  input  logic             i_count,
  output logic             o_done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= iv_load_val;
    end else if (i_count && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  always_comb begin
    o_done = (cnt == '0);
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Two-source (time-sensitive / best-effort) egress frame scheduler with
// registered byte forwarding, inter-frame gap and frame error detection.
module tx_frame_scheduler
  import tx_frame_scheduler_pkg::*;
#(
  parameter int unsigned IFG_CYCLES   = 12,
  parameter int unsigned MAX_LEN      = 1522,
  parameter int unsigned START_WAIT   = 8,
  parameter int unsigned TS_BURST_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ts_req,
  output logic        o_ts_gnt,
  input  logic [7:0]  iv_ts_data,
  input  logic        i_ts_data_wr,
  input  logic        i_ts_last,
  input  logic        i_be_req,
  output logic        o_be_gnt,
  input  logic [7:0]  iv_be_data,
  input  logic        i_be_data_wr,
  input  logic        i_be_last,
  output logic [7:0]  ov_pkt_data,
  output logic        o_pkt_data_wr,
  input  logic        i_fifo_overflow_pulse,
  output logic        o_gap_err,
  output logic        o_len_err,
  output logic        o_start_timeout,
  output logic [15:0] ov_ts_frame_cnt,
  output logic [15:0] ov_be_frame_cnt,
  output logic [7:0]  ov_overflow_cnt
);

  localparam int unsigned IFG_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int unsigned WAIT_W  = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;
  localparam int unsigned BURST_W = $clog2(TS_BURST_MAX + 1);

  localparam logic [IFG_W-1:0]      IFG_LOAD    = IFG_W'(IFG_CYCLES - 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST   = WAIT_W'(START_WAIT - 1);
  localparam logic [BURST_W-1:0]    BURST_MAX_C = BURST_W'(TS_BURST_MAX);
  localparam logic [BYTE_CNT_W-1:0] MAX_LEN_C   = BYTE_CNT_W'(MAX_LEN);

  state_t                 state;
  src_t                   src;
  logic [BURST_W-1:0]     ts_burst_cnt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [BYTE_CNT_W-1:0]  byte_cnt;
  logic                   len_drop;

  logic       sel_wr;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       ts_pick;
  logic       ifg_load;
  logic       ifg_count;
  logic       ifg_done;

  always_comb begin
    sel_wr    = (src == SRC_TS) ? i_ts_data_wr : i_be_data_wr;
    sel_last  = (src == SRC_TS) ? i_ts_last    : i_be_last;
    sel_data  = (src == SRC_TS) ? iv_ts_data   : iv_be_data;
    // TS wins unless it has used its burst allowance while BE is waiting.
    ts_pick   = i_ts_req && !((ts_burst_cnt == BURST_MAX_C) && i_be_req);
    // Timer sits preloaded outside IFG so it starts counting on entry.
    ifg_load  = (state != ST_IFG);
    ifg_count = (state == ST_IFG);
  end

  tx_frame_scheduler_ifg_timer #(
    .WIDTH(IFG_W)
  ) u_ifg_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (ifg_load),
    .iv_load_val (IFG_LOAD),
    .i_count     (ifg_count),
    .o_done      (ifg_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      src             <= SRC_TS;
      ts_burst_cnt    <= '0;
      wait_cnt        <= '0;
      byte_cnt        <= '0;
      len_drop        <= 1'b0;
      o_ts_gnt        <= 1'b0;
      o_be_gnt        <= 1'b0;
      ov_pkt_data     <= '0;
      o_pkt_data_wr   <= 1'b0;
      o_gap_err       <= 1'b0;
      o_len_err       <= 1'b0;
      o_start_timeout <= 1'b0;
      ov_ts_frame_cnt <= '0;
      ov_be_frame_cnt <= '0;
      ov_overflow_cnt <= '0;
    end else begin
      o_ts_gnt        <= 1'b0;
      o_be_gnt        <= 1'b0;
      o_pkt_data_wr   <= 1'b0;
      o_gap_err       <= 1'b0;
      o_len_err       <= 1'b0;
      o_start_timeout <= 1'b0;

      if (i_fifo_overflow_pulse) begin
        ov_overflow_cnt <= sat_inc8(ov_overflow_cnt);
      end

      case (state)
        ST_IDLE: begin
          if (ts_pick) begin
            src      <= SRC_TS;
            o_ts_gnt <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_GRANT;
            if (ts_burst_cnt != BURST_MAX_C) begin
              ts_burst_cnt <= ts_burst_cnt + BURST_W'(1);
            end
          end else if (i_be_req) begin
            src          <= SRC_BE;
            o_be_gnt     <= 1'b1;
            wait_cnt     <= '0;
            ts_burst_cnt <= '0;
            state        <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (sel_wr) begin
            o_pkt_data_wr <= 1'b1;
            ov_pkt_data   <= sel_data;
            byte_cnt      <= BYTE_CNT_W'(1);
            len_drop      <= 1'b0;
            if (sel_last) begin
              if (src == SRC_TS) ov_ts_frame_cnt <= ov_ts_frame_cnt + 16'd1;
              else               ov_be_frame_cnt <= ov_be_frame_cnt + 16'd1;
              state <= ST_IFG;
            end else begin
              state <= ST_XMIT;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            o_start_timeout <= 1'b1;
            state           <= ST_IFG;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ST_XMIT: begin
          if (!sel_wr) begin
            // A stall after a length overrun closes the frame quietly so
            // only one error is reported per frame.
            if (!len_drop) o_gap_err <= 1'b1;
            state <= ST_IFG;
          end else if (len_drop || (byte_cnt == MAX_LEN_C)) begin
            if (!len_drop) o_len_err <= 1'b1;
            len_drop <= 1'b1;
            if (sel_last) state <= ST_IFG;
          end else begin
            o_pkt_data_wr <= 1'b1;
            ov_pkt_data   <= sel_data;
            byte_cnt      <= byte_cnt + BYTE_CNT_W'(1);
            if (sel_last) begin
              if (src == SRC_TS) ov_ts_frame_cnt <= ov_ts_frame_cnt + 16'd1;
              else               ov_be_frame_cnt <= ov_be_frame_cnt + 16'd1;
              state <= ST_IFG;
            end
          end
        end

        ST_IFG: begin
          if (ifg_done) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench for tx_frame_scheduler: expected bytes are queued as the
// sources drive them and checked, with their arrival cycle, at the output.
module tb_tx_frame_scheduler;
  import tx_frame_scheduler_pkg::*;

  localparam int unsigned IFG_CYCLES   = 12;
  localparam int unsigned MAX_LEN      = 1522;
  localparam int unsigned START_WAIT   = 8;
  localparam int unsigned TS_BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_ts_req = 1'b0, i_be_req = 1'b0;
  logic        o_ts_gnt, o_be_gnt;
  logic [7:0]  iv_ts_data = '0, iv_be_data = '0;
  logic        i_ts_data_wr = 1'b0, i_ts_last = 1'b0;
  logic        i_be_data_wr = 1'b0, i_be_last = 1'b0;
  logic [7:0]  ov_pkt_data;
  logic        o_pkt_data_wr;
  logic        i_fifo_overflow_pulse = 1'b0;
  logic        o_gap_err, o_len_err, o_start_timeout;
  logic [15:0] ov_ts_frame_cnt, ov_be_frame_cnt;
  logic [7:0]  ov_overflow_cnt;

  always #4 clk = ~clk;

  tx_frame_scheduler #(
    .IFG_CYCLES  (IFG_CYCLES),
    .MAX_LEN     (MAX_LEN),
    .START_WAIT  (START_WAIT),
    .TS_BURST_MAX(TS_BURST_MAX)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_ts_req             (i_ts_req),
    .o_ts_gnt             (o_ts_gnt),
    .iv_ts_data           (iv_ts_data),
    .i_ts_data_wr         (i_ts_data_wr),
    .i_ts_last            (i_ts_last),
    .i_be_req             (i_be_req),
    .o_be_gnt             (o_be_gnt),
    .iv_be_data           (iv_be_data),
    .i_be_data_wr         (i_be_data_wr),
    .i_be_last            (i_be_last),
    .ov_pkt_data          (ov_pkt_data),
    .o_pkt_data_wr        (o_pkt_data_wr),
    .i_fifo_overflow_pulse(i_fifo_overflow_pulse),
    .o_gap_err            (o_gap_err),
    .o_len_err            (o_len_err),
    .o_start_timeout      (o_start_timeout),
    .ov_ts_frame_cnt      (ov_ts_frame_cnt),
    .ov_be_frame_cnt      (ov_be_frame_cnt),
    .ov_overflow_cnt      (ov_overflow_cnt)
  );

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned out_bytes = 0;
  int unsigned gap_pulses = 0, len_pulses = 0, to_pulses = 0, to_cyc = 0;
  logic [2:0]  err_now, err_prev = '0;
  logic [15:0] exp_ts_frames = '0, exp_be_frames = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_pkt_data_wr) begin
      out_bytes++;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte: got %02h at cycle %0d, want no byte", ov_pkt_data, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (ov_pkt_data !== mon_e.data || cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL pkt_data: got %02h at cycle %0d, want %02h at cycle %0d",
                   ov_pkt_data, cyc, mon_e.data, mon_e.cyc);
        end
      end
    end
    err_now = {o_gap_err, o_len_err, o_start_timeout};
    if (o_gap_err) gap_pulses++;
    if (o_len_err) len_pulses++;
    if (o_start_timeout) begin
      to_pulses++;
      to_cyc = cyc;
    end
    if (err_now != '0) begin
      total++;
      if ($countones(err_now) != 1 || (err_now & err_prev) != '0) begin
        bad++;
        $display("FAIL err_pulse_shape: got now=%03b prev=%03b, want one bit for one cycle",
                 err_now, err_prev);
      end
    end
    err_prev = err_now;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_data();
    i_ts_data_wr = 1'b0; i_ts_last = 1'b0; iv_ts_data = '0;
    i_be_data_wr = 1'b0; i_be_last = 1'b0; iv_be_data = '0;
  endtask

  task automatic reset_dut();
    i_ts_req = 1'b0; i_be_req = 1'b0; i_fifo_overflow_pulse = 1'b0;
    clear_data();
    rst_n = 1'b0;
    tick(); tick();
    sb_q.delete();
    exp_ts_frames = '0;
    exp_be_frames = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_gnt(output logic got, output src_t which, output int unsigned gcyc);
    got = 1'b0; which = SRC_TS; gcyc = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (o_ts_gnt || o_be_gnt) begin
        got = 1'b1;
        which = o_be_gnt ? SRC_BE : SRC_TS;
        gcyc = cyc;
        return;
      end
    end
  endtask

  // Drives n contiguous bytes on source s while the other source streams junk.
  task automatic send_bytes(input src_t s, input int unsigned n, input logic with_last);
    exp_t       e;
    logic [7:0] b;
    for (int unsigned i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (s == SRC_TS) begin
        iv_ts_data = b; i_ts_data_wr = 1'b1; i_ts_last = with_last && (i == n - 1);
        iv_be_data = 8'($urandom); i_be_data_wr = 1'b1; i_be_last = 1'($urandom);
      end else begin
        iv_be_data = b; i_be_data_wr = 1'b1; i_be_last = with_last && (i == n - 1);
        iv_ts_data = 8'($urandom); i_ts_data_wr = 1'b1; i_ts_last = 1'($urandom);
      end
      if (i < MAX_LEN) begin
        e.data = b;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
      end
      tick();
    end
    clear_data();
    if (with_last && n <= MAX_LEN) begin
      if (s == SRC_TS) exp_ts_frames = exp_ts_frames + 16'd1;
      else             exp_be_frames = exp_be_frames + 16'd1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if ({o_ts_gnt, o_be_gnt, o_pkt_data_wr, ov_pkt_data, o_gap_err, o_len_err, o_start_timeout,
         ov_ts_frame_cnt, ov_be_frame_cnt, ov_overflow_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got wr=%b data=%02h ts=%0d be=%0d ovf=%0d, want all zero",
               o_pkt_data_wr, ov_pkt_data, ov_ts_frame_cnt, ov_be_frame_cnt, ov_overflow_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pass_through();
    logic got; src_t which; int unsigned gcyc, k, ob0;
    ob0 = out_bytes;
    i_ts_req = 1'b1;
    wait_gnt(got, which, gcyc);
    i_ts_req = 1'b0;
    total++;
    if (!got || which != SRC_TS) begin
      bad++;
      $display("FAIL pt_grant: got got=%b src=%0d, want TS grant", got, which);
    end
    send_bytes(SRC_TS, 64, 1'b1);
    k = cyc;
    total++;
    if (ov_ts_frame_cnt !== exp_ts_frames || exp_ts_frames != 16'd1) begin
      bad++;
      $display("FAIL pt_frame_cnt: got %0d, want 1", ov_ts_frame_cnt);
    end
    total++;
    if (out_bytes - ob0 != 63) begin
      bad++;
      $display("FAIL pt_byte_count: got %0d before last-byte cycle, want 63", out_bytes - ob0);
    end
    i_ts_req = 1'b1;
    wait_gnt(got, which, gcyc);
    i_ts_req = 1'b0;
    total++;
    if (!got || gcyc - k != IFG_CYCLES + 1) begin
      bad++;
      $display("FAIL pt_ifg_gap: got grant %0d cycles after last byte, want %0d",
               gcyc - k, IFG_CYCLES + 1);
    end
    send_bytes(SRC_TS, 4, 1'b1);
    tick(); tick();
    total++;
    if (ov_ts_frame_cnt !== exp_ts_frames || sb_q.size() != 0) begin
      bad++;
      $display("FAIL pt_second_frame: got cnt=%0d pending=%0d, want cnt=%0d pending=0",
               ov_ts_frame_cnt, sb_q.size(), exp_ts_frames);
    end
  endtask

  task automatic test_priority();
    logic got; src_t which, want;
    int unsigned gcyc;
    reset_dut();
    i_ts_req = 1'b1;
    i_be_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      want = (g % 5 == 4) ? SRC_BE : SRC_TS;
      wait_gnt(got, which, gcyc);
      total++;
      if (!got || which != want) begin
        bad++;
        $display("FAIL prio_grant_%0d: got got=%b src=%0d, want src=%0d", g, got, which, want);
      end
      if (g == 9) begin
        i_ts_req = 1'b0;
        i_be_req = 1'b0;
      end
      if (got) send_bytes(which, 2, 1'b1);
    end
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (ov_ts_frame_cnt !== exp_ts_frames || ov_be_frame_cnt !== exp_be_frames ||
        exp_ts_frames != 16'd8) begin
      bad++;
      $display("FAIL prio_frame_cnt: got ts=%0d be=%0d, want ts=8 be=2",
               ov_ts_frame_cnt, ov_be_frame_cnt);
    end
  endtask

  task automatic test_gap_error();
    logic got; src_t which; int unsigned gcyc, g0, l0, t0, ob0;
    g0 = gap_pulses; l0 = len_pulses; t0 = to_pulses; ob0 = out_bytes;
    i_ts_req = 1'b1;
    wait_gnt(got, which, gcyc);
    i_ts_req = 1'b0;
    send_bytes(SRC_TS, 10, 1'b0);
    tick(); tick(); tick();
    total++;
    if (gap_pulses - g0 != 1 || len_pulses != l0 || to_pulses != t0) begin
      bad++;
      $display("FAIL gap_pulse: got gap=%0d len=%0d to=%0d, want gap=1 others=0",
               gap_pulses - g0, len_pulses - l0, to_pulses - t0);
    end
    total++;
    if (out_bytes - ob0 != 10 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL gap_bytes: got %0d bytes pending=%0d, want 10 pending=0",
               out_bytes - ob0, sb_q.size());
    end
    total++;
    if (ov_ts_frame_cnt !== exp_ts_frames) begin
      bad++;
      $display("FAIL gap_frame_cnt: got %0d, want %0d", ov_ts_frame_cnt, exp_ts_frames);
    end
  endtask

  task automatic test_length_error();
    logic got; src_t which; int unsigned gcyc, k, l0, ob0;
    l0 = len_pulses; ob0 = out_bytes;
    i_be_req = 1'b1;
    wait_gnt(got, which, gcyc);
    i_be_req = 1'b0;
    send_bytes(SRC_BE, 1600, 1'b1);
    k = cyc;
    total++;
    if (out_bytes - ob0 != MAX_LEN || len_pulses - l0 != 1) begin
      bad++;
      $display("FAIL len_overrun: got bytes=%0d len_pulses=%0d, want bytes=%0d len_pulses=1",
               out_bytes - ob0, len_pulses - l0, MAX_LEN);
    end
    i_be_req = 1'b1;
    wait_gnt(got, which, gcyc);
    i_be_req = 1'b0;
    total++;
    if (!got || which != SRC_BE || gcyc - k != IFG_CYCLES + 1) begin
      bad++;
      $display("FAIL len_ifg: got grant %0d cycles after last byte, want %0d",
               gcyc - k, IFG_CYCLES + 1);
    end
    send_bytes(SRC_BE, 1, 1'b1);
    tick(); tick();
    total++;
    if (ov_be_frame_cnt !== exp_be_frames || sb_q.size() != 0) begin
      bad++;
      $display("FAIL len_be_cnt: got %0d pending=%0d, want %0d pending=0",
               ov_be_frame_cnt, sb_q.size(), exp_be_frames);
    end
  endtask

  task automatic test_timeout_overflow();
    logic got; src_t which; int unsigned gcyc, t0;
    t0 = to_pulses;
    i_ts_req = 1'b1;
    wait_gnt(got, which, gcyc);
    i_ts_req = 1'b0;
    for (int unsigned i = 0; i < START_WAIT + 3; i++) tick();
    total++;
    if (to_pulses - t0 != 1 || to_cyc != gcyc + START_WAIT) begin
      bad++;
      $display("FAIL start_timeout: got pulses=%0d at cycle %0d, want 1 at cycle %0d",
               to_pulses - t0, to_cyc, gcyc + START_WAIT);
    end
    for (int i = 0; i < 100; i++) begin
      i_fifo_overflow_pulse = 1'b1;
      tick();
    end
    i_fifo_overflow_pulse = 1'b0;
    total++;
    if (ov_overflow_cnt !== 8'd100) begin
      bad++;
      $display("FAIL ovf_cnt_100: got %0d, want 100", ov_overflow_cnt);
    end
    for (int i = 0; i < 200; i++) begin
      i_fifo_overflow_pulse = 1'b1;
      tick();
    end
    i_fifo_overflow_pulse = 1'b0;
    tick();
    total++;
    if (ov_overflow_cnt !== 8'd255) begin
      bad++;
      $display("FAIL ovf_cnt_sat: got %0d, want 255", ov_overflow_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic got; src_t which; int unsigned gcyc, g0, l0, t0;
    for (int i = 0; i < 20; i++) tick();
    i_ts_req = 1'b1;
    wait_gnt(got, which, gcyc);
    i_ts_req = 1'b0;
    send_bytes(SRC_TS, 5, 1'b0);
    total++;
    if (o_pkt_data_wr !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_wr: got %b, want 1 while frame is streaming", o_pkt_data_wr);
    end
    g0 = gap_pulses; l0 = len_pulses; t0 = to_pulses;
    rst_n = 1'b0;
    #1;
    total++;
    if (o_pkt_data_wr !== 1'b0 || ov_ts_frame_cnt !== '0 || ov_be_frame_cnt !== '0 ||
        ov_overflow_cnt !== '0) begin
      bad++;
      $display("FAIL rst_mid_frame: got wr=%b ts=%0d be=%0d ovf=%0d, want all zero",
               o_pkt_data_wr, ov_pkt_data_wr_dummy(), ov_be_frame_cnt, ov_overflow_cnt);
    end
    sb_q.delete();
    exp_ts_frames = '0;
    exp_be_frames = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    total++;
    if (gap_pulses != g0 || len_pulses != l0 || to_pulses != t0) begin
      bad++;
      $display("FAIL rst_no_err: got gap=%0d len=%0d to=%0d new pulses, want 0",
               gap_pulses - g0, len_pulses - l0, to_pulses - t0);
    end
    i_ts_req = 1'b1;
    wait_gnt(got, which, gcyc);
    i_ts_req = 1'b0;
    total++;
    if (!got || which != SRC_TS) begin
      bad++;
      $display("FAIL rst_regrant: got got=%b src=%0d, want TS grant", got, which);
    end
    send_bytes(SRC_TS, 3, 1'b1);
    tick(); tick();
    total++;
    if (ov_ts_frame_cnt !== 16'd1 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL rst_resume: got cnt=%0d pending=%0d, want cnt=1 pending=0",
               ov_ts_frame_cnt, sb_q.size());
    end
  endtask

  function automatic logic [15:0] ov_pkt_data_wr_dummy();
    return ov_ts_frame_cnt;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by %0t, want finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pass_through();
    test_priority();
    test_gap_error();
    test_length_error();
    test_timeout_overflow();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_scheduler.md
TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 The block SHALL have parameter IFG_CYCLES, default 12: idle cycles enforced between frames on the output.
REQ-002 The block SHALL have parameter MAX_LEN, default 1522: maximum bytes forwarded per frame.
REQ-003 The block SHALL have parameter START_WAIT, default 8: cycles allowed from grant to first byte.
REQ-004 The block SHALL have parameter TS_BURST_MAX, default 4: consecutive TS grants allowed while BE waits.
REQ-005 The block SHALL have these ports, one per line:
- i_clk  in  1  core clock, 125 MHz; the only clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ts_req  in  1  time-sensitive frame pending.
- o_ts_gnt  out  1  one-cycle grant pulse to the TS source.
- iv_ts_data  in  8  TS byte.
- i_ts_data_wr  in  1  TS byte valid.
- i_ts_last  in  1  last TS byte, qualified by i_ts_data_wr.
- i_be_req, o_be_gnt, iv_be_data[7:0], i_be_data_wr, i_be_last  same roles for the best-effort source.
- ov_pkt_data  out  8  byte to the core-to-GMII crossing FIFO.
- o_pkt_data_wr  out  1  byte write strobe.
- i_fifo_overflow_pulse  in  1  overflow pulse from the crossing stage.
- o_gap_err  out  1  pulse: source dropped data_wr mid-frame.
- o_len_err  out  1  pulse: frame exceeded MAX_LEN.
- o_start_timeout  out  1  pulse: no first byte within START_WAIT.
- ov_ts_frame_cnt, ov_be_frame_cnt  out  16  completed frames per source, wrapping.
- ov_overflow_cnt  out  8  overflow pulses, saturating at 255.

Function
REQ-006 The state machine SHALL have four states, IDLE, GRANT, XMIT and IFG, with 2-bit encoding.
REQ-007 In IDLE, the TS source SHALL be selected if i_ts_req=1, unless ts_burst_cnt==TS_BURST_MAX and i_be_req=1, in which case BE SHALL be selected; BE is otherwise selected when only i_be_req=1.
REQ-008 On selection, the block SHALL latch the selected source, pulse the matching gnt for exactly one cycle (the cycle after the IDLE decision), and enter GRANT.
REQ-009 ts_burst_cnt SHALL increment on each TS grant, saturating at TS_BURST_MAX, and SHALL clear on each BE grant.
REQ-010 In GRANT, a wait counter SHALL count cycles; the selected data_wr=1 SHALL enter XMIT with that byte forwarded.
REQ-011 If START_WAIT cycles elapse in GRANT without data_wr, o_start_timeout SHALL pulse once and the block SHALL go to IFG.
REQ-012 Forwarding SHALL be registered with one-cycle latency: ov_pkt_data and o_pkt_data_wr equal the selected source's data and data_wr of the previous cycle; the unselected source is ignored.
REQ-013 In XMIT, a 11-bit byte counter SHALL count forwarded bytes, including the first.
REQ-014 Data_wr with last=1 SHALL forward that byte, increment the source's frame counter, and go to IFG.
REQ-015 A data_wr=0 cycle in XMIT SHALL pulse o_gap_err once, end the frame without a frame-count increment, and go to IFG; the byte stream must be contiguous because the crossing stage frames on FIFO empty.
REQ-016 A byte arriving after MAX_LEN bytes SHALL NOT be forwarded: o_len_err SHALL pulse once, further bytes SHALL be discarded until last or data_wr=0, then the block SHALL go to IFG with no frame-count increment.
REQ-017 IFG SHALL hold o_pkt_data_wr=0 for exactly IFG_CYCLES cycles, then enter IDLE; requests during IFG are only sampled in IDLE.
REQ-018 Every i_fifo_overflow_pulse cycle SHALL increment ov_overflow_cnt, saturating, in any state; it SHALL NOT alter sequencing.
REQ-019 Error pulses SHALL be mutually exclusive per frame and each exactly one cycle wide.

Reset
REQ-020 Asserting i_rst_n=0 SHALL asynchronously force IDLE, clear all outputs, all counters and ts_burst_cnt to 0, and clear the latched source.
REQ-021 Reset mid-frame SHALL truncate output immediately, with no error pulse; after release, sequencing SHALL resume from IDLE.

Structure
REQ-022 The state encodings and the source IDs (TS=0, BE=1) SHALL be placed in a shared package or include.
REQ-023 A single sub-module, ifg_timer (load/count/done), is natural and MAY be reused by other egress ports; all other logic stays flat.

Verification
REQ-024 Frame pass-through: TS request, then a 64-byte contiguous frame -> 64 o_pkt_data_wr cycles with data delayed by 1 cycle, ov_ts_frame_cnt=1, and 12 idle cycles before the next grant.
REQ-025 Priority and starvation: both requests held continuously -> grants TS,TS,TS,TS,BE,TS...
REQ-026 Gap error: data_wr dropped after byte 10 -> o_gap_err single pulse, 10 bytes out, frame count unchanged.
REQ-027 Length error: 1600-byte frame -> exactly 1522 bytes out, one o_len_err pulse, then IFG after the last byte.
REQ-028 Timeout and overflow: grant with no data for 8 cycles -> o_start_timeout pulse; 300 overflow pulses -> ov_overflow_cnt=255.
REQ-029 Reset in XMIT: o_pkt_data_wr=0 the same cycle, all counters 0, and a new request is granted normally after release.
